// File: rtl/fl_check_pkg.sv
// Shared state encoding, error bits and byte-count helpers for the FrameLink frame checker.
package fl_check_pkg;

    localparam int unsigned BYTE_CNT_W = 16;

    localparam logic [2:0] ERR_ORDER = 3'b001;
    localparam logic [2:0] ERR_COUNT = 3'b010;
    localparam logic [2:0] ERR_SIZE  = 3'b100;

    typedef enum logic [1:0] {
        WAIT_SOF,
        IN_PART,
        WAIT_SOP,
        ORPHAN
    } chk_state_t;

    function automatic logic [BYTE_CNT_W-1:0] byte_sat_add(
        input logic [BYTE_CNT_W-1:0] a,
        input logic [BYTE_CNT_W-1:0] b
    );
        logic [BYTE_CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[BYTE_CNT_W] ? '1 : sum[BYTE_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/fl_skid_reg.sv
// Two-slot registered skid stage with active-low FrameLink handshake.
module fl_skid_reg #(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_src_rdy_n,
    output logic             in_dst_rdy_n,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src_rdy_n,
    input  logic             out_dst_rdy_n
);

    logic             out_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             in_xfer;
    logic             out_free;

    assign in_xfer       = !in_src_rdy_n && !in_dst_rdy_n;
    assign out_free      = !out_valid || !out_dst_rdy_n;
    assign out_src_rdy_n = !out_valid;

    // in_dst_rdy_n mirrors skid_valid, so an input transfer never meets a full skid slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_data     <= RESET_VAL;
            skid_valid   <= 1'b0;
            skid_data    <= '0;
            in_dst_rdy_n <= 1'b1;
        end else if (out_free) begin
            in_dst_rdy_n <= 1'b0;
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_data    <= in_data;
            skid_valid   <= 1'b1;
            in_dst_rdy_n <= 1'b1;
        end else begin
            in_dst_rdy_n <= skid_valid;
        end
    end

endmodule

// File: rtl/fl_frame_checker.sv
// FrameLink pass-through stage that checks SOF/SOP/EOP/EOF structure, part count and part sizes,
// reporting one verdict per frame and keeping frame/error counters.
module fl_frame_checker
    import fl_check_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned DREM_WIDTH    = 3,
    parameter int unsigned PART_COUNT    = 3,
    parameter int unsigned PART_SIZE_MIN = 1,
    parameter int unsigned PART_SIZE_MAX = 1536,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic [DREM_WIDTH-1:0] RX_REM,
    input  logic                  RX_SOF_N,
    input  logic                  RX_SOP_N,
    input  logic                  RX_EOP_N,
    input  logic                  RX_EOF_N,
    input  logic                  RX_SRC_RDY_N,
    output logic                  RX_DST_RDY_N,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic [DREM_WIDTH-1:0] TX_REM,
    output logic                  TX_SOF_N,
    output logic                  TX_SOP_N,
    output logic                  TX_EOP_N,
    output logic                  TX_EOF_N,
    output logic                  TX_SRC_RDY_N,
    input  logic                  TX_DST_RDY_N,
    output logic                  FRAME_OK,
    output logic                  FRAME_ERR,
    output logic [2:0]            ERR_CODE,
    output logic [CNT_WIDTH-1:0]  FRAME_CNT,
    output logic [CNT_WIDTH-1:0]  ERR_CNT
);

    localparam int unsigned     FL_W    = DATA_WIDTH + DREM_WIDTH + 4;
    localparam logic [FL_W-1:0] FL_IDLE = FL_W'(4'hF);

    logic [FL_W-1:0] tx_word;

    fl_skid_reg #(
        .WIDTH     (FL_W),
        .RESET_VAL (FL_IDLE)
    ) u_skid (
        .clk           (CLK),
        .reset         (RESET),
        .in_data       ({RX_DATA, RX_REM, RX_SOF_N, RX_SOP_N, RX_EOP_N, RX_EOF_N}),
        .in_src_rdy_n  (RX_SRC_RDY_N),
        .in_dst_rdy_n  (RX_DST_RDY_N),
        .out_data      (tx_word),
        .out_src_rdy_n (TX_SRC_RDY_N),
        .out_dst_rdy_n (TX_DST_RDY_N)
    );

    assign {TX_DATA, TX_REM, TX_SOF_N, TX_SOP_N, TX_EOP_N, TX_EOF_N} = tx_word;

    logic rx_xfer, sof, sop, eop, eof;
    assign rx_xfer = !RX_SRC_RDY_N && !RX_DST_RDY_N;
    assign sof     = !RX_SOF_N;
    assign sop     = !RX_SOP_N;
    assign eop     = !RX_EOP_N;
    assign eof     = !RX_EOF_N;

    chk_state_t             state_q, state_d;
    logic [3:0]             parts_q, parts_d, base_parts, parts_inc;
    logic [BYTE_CNT_W-1:0]  bytes_q, bytes_d, base_bytes, word_bytes, part_bytes;
    logic [2:0]             err_q, err_d, base_err, frame_err;
    logic                   do_body;
    logic                   verdict_d;
    logic [2:0]             verdict_code_d;

    assign word_bytes = eop ? BYTE_CNT_W'(RX_REM) + BYTE_CNT_W'(1) : BYTE_CNT_W'(DATA_WIDTH / 8);
    assign part_bytes = byte_sat_add(base_bytes, word_bytes);
    assign parts_inc  = (parts_q == 4'hF) ? 4'hF : parts_q + 4'd1;

    // Each transfer first selects the part context it belongs to (fresh frame, new part or
    // continuing part), then one shared body does byte accounting and EOP/EOF checks.
    always_comb begin
        state_d        = state_q;
        parts_d        = parts_q;
        bytes_d        = bytes_q;
        err_d          = err_q;
        base_parts     = parts_q;
        base_bytes     = bytes_q;
        base_err       = err_q;
        do_body        = 1'b0;
        verdict_d      = 1'b0;
        verdict_code_d = err_q;
        frame_err      = '0;
        if (rx_xfer) begin
            if (sof) begin
                if (state_q != WAIT_SOF) begin
                    verdict_d      = 1'b1;
                    verdict_code_d = err_q | ERR_ORDER;
                end
                base_parts = 4'd1;
                base_bytes = '0;
                base_err   = sop ? 3'b000 : ERR_ORDER;
                do_body    = 1'b1;
            end else begin
                case (state_q)
                    WAIT_SOF: begin
                        if (eof) begin
                            verdict_d      = 1'b1;
                            verdict_code_d = ERR_ORDER;
                            err_d          = '0;
                        end else begin
                            state_d = ORPHAN;
                            err_d   = ERR_ORDER;
                        end
                    end
                    ORPHAN: begin
                        if (eof) begin
                            verdict_d      = 1'b1;
                            verdict_code_d = err_q;
                            state_d        = WAIT_SOF;
                            err_d          = '0;
                        end
                    end
                    IN_PART: begin
                        base_err = err_q | (sop ? ERR_ORDER : 3'b000);
                        do_body  = 1'b1;
                    end
                    WAIT_SOP: begin
                        base_parts = parts_inc;
                        base_bytes = '0;
                        base_err   = err_q | (sop ? 3'b000 : ERR_ORDER);
                        do_body    = 1'b1;
                    end
                    default: state_d = WAIT_SOF;
                endcase
            end
            if (do_body) begin
                frame_err = base_err;
                parts_d   = base_parts;
                bytes_d   = eop ? '0 : part_bytes;
                if (eop && (part_bytes < BYTE_CNT_W'(PART_SIZE_MIN) ||
                            part_bytes > BYTE_CNT_W'(PART_SIZE_MAX)))
                    frame_err = frame_err | ERR_SIZE;
                if (eof) begin
                    if (!eop)
                        frame_err = frame_err | ERR_ORDER;
                    if (base_parts != 4'(PART_COUNT))
                        frame_err = frame_err | ERR_COUNT;
                    if (!verdict_d) begin
                        verdict_d      = 1'b1;
                        verdict_code_d = frame_err;
                    end
                    state_d = WAIT_SOF;
                    err_d   = '0;
                end else begin
                    state_d = eop ? WAIT_SOP : IN_PART;
                    err_d   = frame_err;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= WAIT_SOF;
            parts_q   <= '0;
            bytes_q   <= '0;
            err_q     <= '0;
            FRAME_OK  <= 1'b0;
            FRAME_ERR <= 1'b0;
            ERR_CODE  <= '0;
            FRAME_CNT <= '0;
            ERR_CNT   <= '0;
        end else begin
            state_q   <= state_d;
            parts_q   <= parts_d;
            bytes_q   <= bytes_d;
            err_q     <= err_d;
            FRAME_OK  <= verdict_d && (verdict_code_d == 3'b000);
            FRAME_ERR <= verdict_d && (verdict_code_d != 3'b000);
            if (verdict_d) begin
                ERR_CODE  <= verdict_code_d;
                FRAME_CNT <= FRAME_CNT + CNT_WIDTH'(1);
                if (verdict_code_d != 3'b000)
                    ERR_CNT <= ERR_CNT + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fl_frame_checker.sv
// Randomized scoreboard bench for fl_frame_checker: word pass-through and per-frame verdicts
// are predicted from frame descriptions (part sizes) and checked by an independent monitor.
module tb_fl_frame_checker;

    localparam logic [2:0] E_ORDER = 3'b001;
    localparam logic [2:0] E_COUNT = 3'b010;
    localparam logic [2:0] E_SIZE  = 3'b100;

    typedef struct packed {
        logic [2:0] code;
        logic [2:0] mask;
    } verdict_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [63:0] RX_DATA = '0;
    logic [2:0]  RX_REM = '0;
    logic        RX_SOF_N = 1'b1, RX_SOP_N = 1'b1, RX_EOP_N = 1'b1, RX_EOF_N = 1'b1;
    logic        RX_SRC_RDY_N = 1'b1;
    logic        RX_DST_RDY_N;
    logic [63:0] TX_DATA;
    logic [2:0]  TX_REM;
    logic        TX_SOF_N, TX_SOP_N, TX_EOP_N, TX_EOF_N, TX_SRC_RDY_N;
    logic        TX_DST_RDY_N = 1'b0;
    logic        FRAME_OK, FRAME_ERR;
    logic [2:0]  ERR_CODE;
    logic [31:0] FRAME_CNT, ERR_CNT;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned model_frames = 0;
    int unsigned model_errs = 0;
    int unsigned sizes[4];
    bit          stall_en = 1'b0;
    bit          gap_en = 1'b0;
    logic [70:0] exp_words[$];
    verdict_t    exp_verdicts[$];

    fl_frame_checker #(
        .DATA_WIDTH    (64),
        .DREM_WIDTH    (3),
        .PART_COUNT    (3),
        .PART_SIZE_MIN (1),
        .PART_SIZE_MAX (1536),
        .CNT_WIDTH     (32)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .RX_DATA      (RX_DATA),
        .RX_REM       (RX_REM),
        .RX_SOF_N     (RX_SOF_N),
        .RX_SOP_N     (RX_SOP_N),
        .RX_EOP_N     (RX_EOP_N),
        .RX_EOF_N     (RX_EOF_N),
        .RX_SRC_RDY_N (RX_SRC_RDY_N),
        .RX_DST_RDY_N (RX_DST_RDY_N),
        .TX_DATA      (TX_DATA),
        .TX_REM       (TX_REM),
        .TX_SOF_N     (TX_SOF_N),
        .TX_SOP_N     (TX_SOP_N),
        .TX_EOP_N     (TX_EOP_N),
        .TX_EOF_N     (TX_EOF_N),
        .TX_SRC_RDY_N (TX_SRC_RDY_N),
        .TX_DST_RDY_N (TX_DST_RDY_N),
        .FRAME_OK     (FRAME_OK),
        .FRAME_ERR    (FRAME_ERR),
        .ERR_CODE     (ERR_CODE),
        .FRAME_CNT    (FRAME_CNT),
        .ERR_CNT      (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: everything happens at the falling edge, so values are stable for the next rising edge.
    initial begin
        verdict_t v;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                TX_DST_RDY_N = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
                if (!TX_SRC_RDY_N && !TX_DST_RDY_N) begin
                    if (exp_words.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL tx_unexpected_word: got %h expected none", TX_DATA);
                    end else begin
                        check("tx_word",
                              {9'b0, TX_DATA, TX_REM, TX_SOF_N, TX_SOP_N, TX_EOP_N, TX_EOF_N},
                              {9'b0, exp_words.pop_front()});
                    end
                end
                if (FRAME_OK || FRAME_ERR) begin
                    if (exp_verdicts.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_verdict: got ok=%0b err=%0b code=%b expected none",
                                 FRAME_OK, FRAME_ERR, ERR_CODE);
                    end else begin
                        v = exp_verdicts.pop_front();
                        check("verdict_ok_err", {FRAME_OK, FRAME_ERR}, {v.code == 3'b000, v.code != 3'b000});
                        check("err_code", ERR_CODE & v.mask, v.code);
                    end
                end
            end
        end
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    task automatic send_word(input logic [63:0] d, input logic [2:0] r,
                             input bit sof, input bit sop, input bit eop, input bit eof);
        int unsigned guard;
        if (gap_en && $urandom_range(0, 3) == 0) begin
            RX_SRC_RDY_N = 1'b1;
            @(negedge CLK);
        end
        RX_DATA      = d;
        RX_REM       = r;
        RX_SOF_N     = !sof;
        RX_SOP_N     = !sop;
        RX_EOP_N     = !eop;
        RX_EOF_N     = !eof;
        RX_SRC_RDY_N = 1'b0;
        exp_words.push_back({d, r, !sof, !sop, !eop, !eof});
        guard = 0;
        while (RX_DST_RDY_N && guard < 1000) begin
            @(negedge CLK);
            guard++;
        end
        if (RX_DST_RDY_N) begin
            checks++;
            failures++;
            $display("FAIL rx_ready_timeout: got not-ready expected ready within 1000 cycles");
        end
        @(negedge CLK);
        RX_SRC_RDY_N = 1'b1;
    endtask

    task automatic send_part(input int unsigned nbytes, input bit first, input bit last);
        int unsigned nw;
        bit          is_last;
        logic [2:0]  r;
        nw = (nbytes + 7) / 8;
        for (int unsigned i = 0; i < nw; i++) begin
            is_last = (i == nw - 1);
            r = is_last ? 3'((nbytes - 1) % 8) : 3'($urandom);
            send_word({$urandom, $urandom}, r, first && i == 0, i == 0, is_last, last && is_last);
        end
    endtask

    // Verdict is predicted from the part list alone and queued before any word goes out.
    task automatic send_frame(input int unsigned n);
        verdict_t v;
        v.code = (n != 3) ? E_COUNT : 3'b000;
        for (int unsigned i = 0; i < n; i++)
            if (sizes[i] < 1 || sizes[i] > 1536) v.code = v.code | E_SIZE;
        v.mask = 3'b111;
        exp_verdicts.push_back(v);
        model_frames++;
        if (v.code != 3'b000) model_errs++;
        for (int unsigned i = 0; i < n; i++)
            send_part(sizes[i], i == 0, i == n - 1);
    endtask

    task automatic wait_drain(input string name);
        int unsigned guard;
        guard = 0;
        while ((exp_words.size() != 0 || exp_verdicts.size() != 0) && guard < 5000) begin
            @(negedge CLK);
            guard++;
        end
        checks++;
        if (guard >= 5000) begin
            failures++;
            $display("FAIL drain_%s: got words=%0d verdicts=%0d pending expected 0",
                     name, exp_words.size(), exp_verdicts.size());
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic random_sizes();
        sizes[0] = $urandom_range(1, 128);
        sizes[1] = ($urandom_range(0, 31) == 0) ? $urandom_range(1, 1536) : $urandom_range(1, 64);
        sizes[2] = $urandom_range(1, 128);
        sizes[3] = $urandom_range(1, 64);
    endtask

    initial begin
        verdict_t v;
        int unsigned n;

        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        check("reset_tx_src_rdy_n", TX_SRC_RDY_N, 1'b1);
        check("reset_tx_delims", {TX_SOF_N, TX_SOP_N, TX_EOP_N, TX_EOF_N}, 4'hF);
        check("reset_tx_data_rem", {TX_DATA, TX_REM}, '0);
        check("reset_rx_dst_rdy_n", RX_DST_RDY_N, 1'b1);
        check("reset_verdicts", {FRAME_OK, FRAME_ERR, ERR_CODE}, '0);
        check("reset_counters", {FRAME_CNT, ERR_CNT}, '0);
        RESET = 1'b0;
        @(negedge CLK);

        // Clean traffic, no stalls; include size boundaries 1 and 1536.
        for (int unsigned i = 0; i < 2000; i++) begin
            random_sizes();
            if (i % 500 == 3) sizes[1] = 1536;
            if (i % 500 == 7) sizes[1] = 1;
            send_frame(3);
        end
        wait_drain("t1");
        check("t1_frame_cnt", FRAME_CNT, model_frames);
        check("t1_err_cnt", ERR_CNT, model_errs);

        // Back-pressure and input gaps, with occasional wrong part counts.
        stall_en = 1'b1;
        gap_en   = 1'b1;
        for (int unsigned i = 0; i < 200; i++) begin
            random_sizes();
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 3;
            send_frame(n);
        end

        sizes = '{16, 100, 0, 0};
        send_frame(2);
        sizes = '{40, 24, 8, 0};
        send_frame(3);

        sizes = '{8, 1537, 8, 0};
        send_frame(3);
        sizes = '{8, 1536, 8, 0};
        send_frame(3);

        // SOF arriving inside part 2 closes the old frame as faulty and starts a fresh one.
        v.code = E_ORDER;
        v.mask = E_ORDER;
        exp_verdicts.push_back(v);
        model_frames++;
        model_errs++;
        send_part(16, 1'b1, 1'b0);
        send_word({$urandom, $urandom}, 3'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
        send_word({$urandom, $urandom}, 3'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        sizes = '{24, 33, 9, 0};
        send_frame(3);

        wait_drain("t2_5");
        check("t2_5_frame_cnt", FRAME_CNT, model_frames);
        check("t2_5_err_cnt", ERR_CNT, model_errs);

        // Single-word frame: verdict visible right after its transfer edge.
        stall_en = 1'b0;
        gap_en   = 1'b0;
        repeat (2) @(negedge CLK);
        v.code = E_COUNT;
        v.mask = 3'b111;
        exp_verdicts.push_back(v);
        send_word({$urandom, $urandom}, 3'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        check("single_word_verdict_latency", FRAME_ERR, 1'b1);
        wait_drain("single");

        // Reset mid-frame, then tail words form one orphan frame.
        send_part(16, 1'b1, 1'b0);
        send_word({$urandom, $urandom}, 3'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain("t6_pre");
        RESET = 1'b1;
        @(negedge CLK);
        check("t6_reset_rx_dst_rdy_n", RX_DST_RDY_N, 1'b1);
        check("t6_reset_counters", {FRAME_CNT, ERR_CNT}, '0);
        RESET = 1'b0;
        @(negedge CLK);
        v.code = E_ORDER;
        v.mask = 3'b111;
        exp_verdicts.push_back(v);
        for (int unsigned i = 0; i < 4; i++)
            send_word({$urandom, $urandom}, 3'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        send_word({$urandom, $urandom}, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_drain("t6");
        check("t6_frame_cnt", FRAME_CNT, 32'd1);
        check("t6_err_cnt", ERR_CNT, 32'd1);
        check("t6_err_code_hold", ERR_CODE, E_ORDER);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
